fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the instruction memory. Holds the PC and drives
//  the memory address; the memory returns the instruction combinationally in the same cycle.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage in front of a combinational instruction memory.
//   Holds the PC, drives it as the memory address, and registers the returned
//   instruction into a single output slot with a valid/ready handshake to
//   decode. Handles start, redirect from execute, back-pressure and halt.
//
// Ports
//   clk         in   1           rising-edge clock
//   reset       in   1           asynchronous, active-high reset
//   start       in   1           begin / restart execution at address 0
//   imem_addr   out  ADDR_WIDTH  instruction-memory address (always the PC)
//   imem_data   in   INST_WIDTH  instruction returned for imem_addr
//   inst_out    out  INST_WIDTH  registered instruction to decode
//   inst_pc     out  ADDR_WIDTH  address inst_out was fetched from
//   inst_valid  out  1           inst_out / inst_pc are valid
//   inst_ready  in   1           decode accepts inst_out this cycle
//   br_taken    in   1           redirect request from execute
//   br_target   in   ADDR_WIDTH  redirect address
//   halted      out  1           halt instruction captured, fetch stopped
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned              ADDR_WIDTH = 8,
  parameter int unsigned              INST_WIDTH = 8,
  parameter logic [INST_WIDTH-1:0]    HALT_INST  = 8'b1111_1111
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_data,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  output logic                  halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [INST_WIDTH-1:0]   inst_q;
  logic [ADDR_WIDTH-1:0]   inst_pc_q;
  logic                    valid_q;
  logic                    halted_q;

  // The slot can take a new instruction when it is empty or being drained
  // by decode in this same cycle.
  logic slot_free;
  logic is_halt;

  assign slot_free = !valid_q || inst_ready;
  assign is_halt   = (imem_data == HALT_INST);

  assign imem_addr  = pc_q;
  assign inst_out   = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;
  assign halted     = halted_q;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Redirects are meaningless before execution starts.
          if (start) begin
            state_q <= RUN;
            pc_q    <= '0;
          end
        end

        RUN: begin
          if (br_taken) begin
            // Flush whatever sits in the slot; the redirect target is fetched
            // next cycle. Any acceptance by decode this cycle has happened.
            pc_q    <= br_target;
            valid_q <= 1'b0;
          end else if (slot_free) begin
            inst_q    <= imem_data;
            inst_pc_q <= pc_q;
            valid_q   <= 1'b1;
            if (is_halt) begin
              // PC stays on the halt instruction.
              halted_q <= 1'b1;
              state_q  <= HALTED;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
          // else: stall, everything holds.
        end

        HALTED: begin
          if (start) begin
            // Restart wins over a pending handshake on the halt instruction.
            state_q  <= RUN;
            pc_q     <= '0;
            halted_q <= 1'b0;
            valid_q  <= 1'b0;
          end else if (inst_ready) begin
            valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural instruction memory drives
//   imem_data from imem_addr; expected {instruction, pc} pairs are queued as
//   fetches are set up and popped as decode accepts them.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int AW = 8;
  localparam int IW = 8;
  localparam logic [IW-1:0] HALT = 8'hFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] inst_out;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          halted;

  logic [IW-1:0] mem [0:255];
  logic [IW+AW-1:0] sb [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_unit #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .HALT_INST(HALT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halted     (halted)
  );

  // One clock: inputs set before the call are sampled at the rising edge,
  // outputs are observed at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    start      = 1'b0;
    inst_ready = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse start for one edge; afterwards the DUT is in RUN with pc=0.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_addr, inst_out, inst_pc, inst_valid, halted} !== '0) begin
      errors++;
      $display("FAIL reset_state: addr=%h inst=%h pc=%h valid=%b halted=%b, required all zero",
               imem_addr, inst_out, inst_pc, inst_valid, halted);
    end
    // Idle with redirects offered: nothing may move.
    br_taken  = 1'b1;
    br_target = 8'h40;
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (imem_addr !== 8'h00 || inst_valid !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: addr=%h valid=%b halted=%b, required 00/0/0",
                 i, imem_addr, inst_valid, halted);
      end
    end
    br_taken = 1'b0;
  endtask

  task automatic test_straight_line();
    logic [IW+AW-1:0] exp;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back({mem[i], 8'(i)});
    start_run();
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL start_latency: valid=%b addr=%h one cycle after start, required 0/00",
               inst_valid, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      checks++;
      if (inst_valid !== 1'b1 || {inst_out, inst_pc} !== exp) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b inst=%h pc=%h, required 1 inst=%h pc=%h",
                 i, inst_valid, inst_out, inst_pc, exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    inst_ready = 1'b1;
    start_run();
    tick();
    tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // A start in RUN must not restart the stream.
      start = (i == 1);
      tick();
      checks++;
      if (inst_out !== 8'h22 || inst_pc !== 8'h01 || imem_addr !== 8'h02 || inst_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: inst=%h pc=%h addr=%h valid=%b, required 22/01/02/1",
                 i, inst_out, inst_pc, imem_addr, inst_valid);
      end
    end
    start = 1'b0;
    inst_ready = 1'b1;
    sb.push_back({mem[2], 8'h02});
    tick();
    begin
      logic [IW+AW-1:0] exp;
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      checks++;
      if (inst_valid !== 1'b1 || {inst_out, inst_pc} !== exp) begin
        errors++;
        $display("FAIL stall_resume: inst=%h pc=%h, required inst=%h pc=%h",
                 inst_out, inst_pc, exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_redirect();
    logic [IW+AW-1:0] exp;
    do_reset();
    inst_ready = 1'b1;
    start_run();
    tick();
    br_taken  = 1'b1;
    br_target = 8'h20;
    tick();
    br_taken = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 8'h20) begin
      errors++;
      $display("FAIL redirect_flush: valid=%b addr=%h, required 0/20", inst_valid, imem_addr);
    end
    sb.push_back({mem[8'h20], 8'h20});
    sb.push_back({mem[8'h21], 8'h21});
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      checks++;
      if (inst_valid !== 1'b1 || {inst_out, inst_pc} !== exp) begin
        errors++;
        $display("FAIL redirect_fetch[%0d]: inst=%h pc=%h, required inst=%h pc=%h",
                 i, inst_out, inst_pc, exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_halt();
    logic [IW+AW-1:0] exp;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) sb.push_back({mem[i], 8'(i)});
    start_run();
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      checks++;
      if (inst_valid !== 1'b1 || {inst_out, inst_pc} !== exp) begin
        errors++;
        $display("FAIL halt_stream[%0d]: inst=%h pc=%h, required inst=%h pc=%h",
                 i, inst_out, inst_pc, exp[15:8], exp[7:0]);
      end
    end
    checks++;
    if (halted !== 1'b1 || imem_addr !== 8'h05) begin
      errors++;
      $display("FAIL halt_capture: halted=%b addr=%h, required 1/05", halted, imem_addr);
    end
    // Halt instruction waits for decode; redirects are ignored meanwhile.
    inst_ready = 1'b0;
    br_taken   = 1'b1;
    br_target  = 8'h30;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || halted !== 1'b1 || imem_addr !== 8'h05 || inst_out !== HALT) begin
        errors++;
        $display("FAIL halt_hold[%0d]: valid=%b halted=%b addr=%h inst=%h, required 1/1/05/ff",
                 i, inst_valid, halted, imem_addr, inst_out);
      end
    end
    br_taken   = 1'b0;
    inst_ready = 1'b1;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 8'h05) begin
      errors++;
      $display("FAIL halt_accept: valid=%b halted=%b addr=%h, required 0/1/05",
               inst_valid, halted, imem_addr);
    end
    start_run();
    checks++;
    if (halted !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL halt_restart: halted=%b valid=%b addr=%h, required 0/0/00",
               halted, inst_valid, imem_addr);
    end
    sb.push_back({mem[0], 8'h00});
    tick();
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    checks++;
    if (inst_valid !== 1'b1 || {inst_out, inst_pc} !== exp) begin
      errors++;
      $display("FAIL halt_restart_fetch: inst=%h pc=%h, required inst=%h pc=%h",
               inst_out, inst_pc, exp[15:8], exp[7:0]);
    end
  endtask

  task automatic test_wrap_reset();
    logic [IW+AW-1:0] exp;
    do_reset();
    inst_ready = 1'b1;
    start_run();
    tick();
    br_taken  = 1'b1;
    br_target = 8'hFF;
    tick();
    br_taken = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_redirect: valid=%b addr=%h, required 0/ff", inst_valid, imem_addr);
    end
    sb.push_back({mem[8'hFF], 8'hFF});
    sb.push_back({mem[8'h00], 8'h00});
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      checks++;
      if (inst_valid !== 1'b1 || {inst_out, inst_pc} !== exp) begin
        errors++;
        $display("FAIL wrap_fetch[%0d]: inst=%h pc=%h, required inst=%h pc=%h",
                 i, inst_out, inst_pc, exp[15:8], exp[7:0]);
      end
    end
    // Reset between edges must clear outputs without waiting for a clock.
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({imem_addr, inst_out, inst_pc, inst_valid, halted} !== '0) begin
      errors++;
      $display("FAIL async_reset: addr=%h inst=%h pc=%h valid=%b halted=%b, required all zero",
               imem_addr, inst_out, inst_pc, inst_valid, halted);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    inst_ready = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    // Background pattern never equals the halt encoding.
    for (int i = 0; i < 256; i++) mem[i] = {i[3:0], ~i[3:0]};
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    mem[3] = 8'h44;
    mem[4] = 8'h55;
    mem[5] = HALT;

    test_reset();
    test_straight_line();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
